data_mem_bus_ctrl: RTL and testbench
====================================

// Module: data_mem_bus_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the LSU: turns one LSU word access (LW/SW) into a
//  req/gnt/rvalid transaction on the data-memory bus. Returns load data plus a one-cycle response
//  strobe to the LSU. Misaligned addresses and bus timeouts complete with an error response.
//  One outstanding transaction at a time; the LSU stalls on lsu_ready_op.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in REQ+WAIT_R before an error response (>=2)
// PORTS
//  clock           in   1   core clock
//  reset           in   1   synchronous, active-high
//  lsu_req_ip      in   1   LSU access request, sampled only when lsu_ready_op=1
//  lsu_operator_ip in   enum  load_store_func_code (LW/SW); other codes -> error response
//  lsu_addr_ip     in   32  byte address
//  lsu_wdata_ip    in   32  store data
//  lsu_ready_op    out  1   1 = idle, request accepted this cycle
//  lsu_resp_op     out  1   one-cycle completion strobe
//  lsu_err_op      out  1   valid with lsu_resp_op: misaligned / bad op / timeout
//  lsu_rdata_op    out  32  last load data; holds until next successful load
//  mem_req_op      out  1   bus request
//  mem_we_op       out  1   1 = store
//  mem_be_op       out  4   byte enables, always 4'hF
//  mem_addr_op     out  32  word address {addr[31:2],2'b00}
//  mem_wdata_op    out  32  store data
//  mem_gnt_ip      in   1   bus grant (address phase accepted)
//  mem_rvalid_ip   in   1   response phase valid
//  mem_rdata_ip    in   32  load data, valid with mem_rvalid_ip
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except lsu_ready_op=1; timeout counter 0; lsu_rdata_op 0.
//  All outputs registered or decoded from state; no combinational in->out path.
//  FSM states IDLE, REQ, WAIT_R:
//  - IDLE: lsu_req_ip=1 and LW/SW and addr[1:0]==0 -> latch addr/op/wdata, next cycle REQ.
//    lsu_req_ip=1 and (addr[1:0]!=0 or bad op) -> stay IDLE, lsu_resp_op=lsu_err_op=1 next
//    cycle, no bus activity, lsu_ready_op stays 1.
//  - REQ: mem_req_op=1; addr/we/wdata held stable until gnt. mem_gnt_ip=1 -> WAIT_R next cycle,
//    mem_req_op drops that next cycle.
//  - WAIT_R: mem_rvalid_ip=1 -> next cycle IDLE with lsu_resp_op=1, lsu_err_op=0; for LW
//    lsu_rdata_op<=mem_rdata_ip on the same edge; for SW lsu_rdata_op unchanged.
//  - lsu_ready_op = (state==IDLE). LSU must hold its request while ready=0.
//  Latency (zero-wait bus: gnt in first REQ cycle, rvalid next cycle): accept at cycle 0, REQ at 1,
//    WAIT_R at 2, lsu_resp_op at 3. Misaligned: resp at cycle 1.
//  Timeout: counter cleared on IDLE->REQ, +1 every cycle in REQ/WAIT_R. If counter reaches
//    TIMEOUT_CYCLES-1 without the completing event (gnt in REQ, rvalid in WAIT_R) -> next cycle
//    IDLE, lsu_resp_op=lsu_err_op=1, mem_req_op=0. Completing event in that same cycle wins.
//    Counter width $clog2(TIMEOUT_CYCLES+1); never wraps.
//  mem_rvalid_ip outside WAIT_R ignored (covers late responses after timeout or reset).
//  mem_gnt_ip outside REQ ignored. Bus contract: rvalid no earlier than cycle after gnt.
//  Reset mid-transaction: abandon immediately, IDLE next cycle, no response strobe issued.
// STRUCTURE
//  CORE_PKG: add typedef enum logic [1:0] {DMC_IDLE, DMC_REQ, DMC_WAIT_R} dmem_ctrl_state_e
//    and localparam DMEM_TIMEOUT_DEFAULT=64; reuse load_store_func_code.
//  Flat module; timeout counter inline, no sub-module.
// TESTING
//  LW 0x100, gnt in first REQ cycle, rvalid+rdata 0xDEADBEEF next -> resp at cycle 3, err=0,
//    rdata_op=0xDEADBEEF, mem_addr_op=0x100, be=4'hF, we=0.
//  SW 0x204 data 0x12345678, gnt after 3 wait cycles -> addr/wdata stable through stall,
//    we=1, one resp strobe, rdata_op unchanged.
//  LW 0x102 -> resp+err next cycle, mem_req_op never asserts, ready stays 1.
//  TIMEOUT_CYCLES=8, never gnt -> err resp exactly 8 cycles after entering REQ; late rvalid
//    afterwards ignored (no extra resp).
//  Reset asserted while in WAIT_R -> IDLE, all outputs at reset values, no resp; subsequent
//    LW completes normally.
//  Back-to-back LW then SW with lsu_req_ip held high -> second accepted only on ready=1,
//    exactly two resp strobes.

Source files
------------

// File: rtl/data_mem_bus_ctrl_pkg.sv
// Shared types for the data-memory bus controller: LSU function codes,
// controller FSM states and the default bus timeout.
package data_mem_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LH  = 4'd1,
        LSU_LW  = 4'd2,
        LSU_LBU = 4'd3,
        LSU_LHU = 4'd4,
        LSU_SB  = 4'd5,
        LSU_SH  = 4'd6,
        LSU_SW  = 4'd7
    } load_store_func_code;

    typedef enum logic [1:0] {
        DMC_IDLE   = 2'd0,
        DMC_REQ    = 2'd1,
        DMC_WAIT_R = 2'd2
    } dmem_ctrl_state_e;

    localparam int DMEM_TIMEOUT_DEFAULT = 64;

    // Only full-word accesses travel over this bus; sub-word codes are rejected.
    function automatic logic is_word_op(input load_store_func_code op);
        return (op == LSU_LW) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/data_mem_bus_ctrl.sv
// Memory-side stage behind the LSU: turns one LW/SW into a req/gnt/rvalid bus
// transaction, one outstanding at a time, with misalign/bad-op/timeout errors.
module data_mem_bus_ctrl
    import data_mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lsu_req_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         lsu_addr_ip,
    input  logic [31:0]         lsu_wdata_ip,
    output logic                lsu_ready_op,
    output logic                lsu_resp_op,
    output logic                lsu_err_op,
    output logic [31:0]         lsu_rdata_op,
    output logic                mem_req_op,
    output logic                mem_we_op,
    output logic [3:0]          mem_be_op,
    output logic [31:0]         mem_addr_op,
    output logic [31:0]         mem_wdata_op,
    input  logic                mem_gnt_ip,
    input  logic                mem_rvalid_ip,
    input  logic [31:0]         mem_rdata_ip,
    output dmem_ctrl_state_e    dbg_state_op
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    dmem_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             resp_q, resp_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             timed_out;
    logic             lsu_ok;

    // Handshakes: an LSU request transfers on a cycle with lsu_req_ip && lsu_ready_op;
    // the address phase transfers on mem_req_op && mem_gnt_ip; the response phase is
    // mem_rvalid_ip while in WAIT_R. Each side holds its payload until its transfer.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timed_out = (cnt_q >= CNT_LAST);
    assign lsu_ok    = is_word_op(lsu_operator_ip) && (lsu_addr_ip[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            DMC_IDLE: begin
                if (lsu_req_ip) begin
                    if (lsu_ok) begin
                        state_d = DMC_REQ;
                        cnt_d   = '0;
                        addr_d  = {lsu_addr_ip[31:2], 2'b00};
                        wdata_d = lsu_wdata_ip;
                        we_d    = (lsu_operator_ip == LSU_SW);
                    end else begin
                        resp_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            DMC_REQ: begin
                cnt_d = cnt_inc;
                // A grant in the final counted cycle still beats the timeout.
                if (mem_gnt_ip) begin
                    state_d = DMC_WAIT_R;
                end else if (timed_out) begin
                    state_d = DMC_IDLE;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DMC_WAIT_R: begin
                cnt_d = cnt_inc;
                if (mem_rvalid_ip) begin
                    state_d = DMC_IDLE;
                    resp_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata_ip;
                    end
                end else if (timed_out) begin
                    state_d = DMC_IDLE;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = DMC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DMC_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign lsu_ready_op = (state_q == DMC_IDLE);
    assign lsu_resp_op  = resp_q;
    assign lsu_err_op   = err_q;
    assign lsu_rdata_op = rdata_q;
    assign mem_req_op   = (state_q == DMC_REQ);
    assign mem_we_op    = we_q;
    assign mem_be_op    = 4'hF;
    assign mem_addr_op  = addr_q;
    assign mem_wdata_op = wdata_q;
    assign dbg_state_op = state_q;

endmodule

// File: tb/tb_data_mem_bus_ctrl.sv
// Directed bench for data_mem_bus_ctrl: a vector table of single transactions
// with a scripted bus, plus hand-written timeout, reset and back-to-back sequences.
module tb_data_mem_bus_ctrl;
    import data_mem_bus_ctrl_pkg::*;

    localparam int TMO = 8;

    logic                clock;
    logic                reset;
    logic                lsu_req_ip;
    load_store_func_code lsu_operator_ip;
    logic [31:0]         lsu_addr_ip;
    logic [31:0]         lsu_wdata_ip;
    logic                lsu_ready_op;
    logic                lsu_resp_op;
    logic                lsu_err_op;
    logic [31:0]         lsu_rdata_op;
    logic                mem_req_op;
    logic                mem_we_op;
    logic [3:0]          mem_be_op;
    logic [31:0]         mem_addr_op;
    logic [31:0]         mem_wdata_op;
    logic                mem_gnt_ip;
    logic                mem_rvalid_ip;
    logic [31:0]         mem_rdata_ip;
    dmem_ctrl_state_e    dbg_state_op;

    data_mem_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .lsu_req_ip      (lsu_req_ip),
        .lsu_operator_ip (lsu_operator_ip),
        .lsu_addr_ip     (lsu_addr_ip),
        .lsu_wdata_ip    (lsu_wdata_ip),
        .lsu_ready_op    (lsu_ready_op),
        .lsu_resp_op     (lsu_resp_op),
        .lsu_err_op      (lsu_err_op),
        .lsu_rdata_op    (lsu_rdata_op),
        .mem_req_op      (mem_req_op),
        .mem_we_op       (mem_we_op),
        .mem_be_op       (mem_be_op),
        .mem_addr_op     (mem_addr_op),
        .mem_wdata_op    (mem_wdata_op),
        .mem_gnt_ip      (mem_gnt_ip),
        .mem_rvalid_ip   (mem_rvalid_ip),
        .mem_rdata_ip    (mem_rdata_ip),
        .dbg_state_op    (dbg_state_op)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    // gnt_wait: REQ cycles without grant before the granting cycle (-1 = never).
    // rv: bus answers with rvalid the cycle after the grant.
    typedef struct {
        load_store_func_code op;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        int                  gnt_wait;
        logic                rv;
        logic [31:0]         rdata;
        int                  exp_resp;
        logic                exp_err;
        int                  exp_req;
        logic [31:0]         exp_addr;
        logic                exp_we;
        logic [31:0]         exp_rdata;
    } vec_t;

    function automatic vec_t mk(input load_store_func_code op, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gnt_wait, input logic rv,
                                input logic [31:0] rdata, input int exp_resp, input logic exp_err,
                                input int exp_req, input logic [31:0] exp_addr,
                                input logic exp_we, input logic [31:0] exp_rdata);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.gnt_wait = gnt_wait; v.rv = rv;
        v.rdata = rdata; v.exp_resp = exp_resp; v.exp_err = exp_err; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    vec_t vecs[11];

    // ---------------- driver: one transaction with scripted bus ----------------
    task automatic run_vec(input vec_t v, input int idx);
        int   resp_cyc;
        int   resp_cnt;
        int   req_seen;
        int   busy;
        logic err_seen;
        logic stable_ok;
        logic gnt_prev;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clock);
        check32({tag, "_ready_before"}, {31'b0, lsu_ready_op}, 32'd1);
        lsu_req_ip      = 1'b1;
        lsu_operator_ip = v.op;
        lsu_addr_ip     = v.addr;
        lsu_wdata_ip    = v.wdata;
        resp_cyc = -1; resp_cnt = 0; req_seen = 0; busy = 0;
        err_seen = 1'b0; stable_ok = 1'b1; gnt_prev = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            lsu_req_ip = 1'b0;
            if (lsu_resp_op) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = c;
                    err_seen = lsu_err_op;
                end
            end
            if (!lsu_ready_op) busy++;
            if (mem_req_op) begin
                req_seen++;
                if (mem_addr_op !== v.exp_addr || mem_we_op !== v.exp_we ||
                    mem_wdata_op !== v.wdata || mem_be_op !== 4'hF)
                    stable_ok = 1'b0;
            end
            mem_rvalid_ip = gnt_prev && v.rv;
            mem_rdata_ip  = (gnt_prev && v.rv) ? v.rdata : 32'h0;
            mem_gnt_ip    = mem_req_op && (v.gnt_wait >= 0) && (req_seen > v.gnt_wait);
            gnt_prev      = mem_gnt_ip;
        end
        mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'h0;
        check32({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(v.exp_resp));
        check32({tag, "_err"}, {31'b0, err_seen}, {31'b0, v.exp_err});
        check32({tag, "_resp_count"}, 32'(resp_cnt), 32'd1);
        check32({tag, "_req_cycles"}, 32'(req_seen), 32'(v.exp_req));
        check32({tag, "_bus_stable"}, {31'b0, stable_ok}, 32'd1);
        check32({tag, "_busy_cycles"}, 32'(busy), (v.exp_req == 0) ? 32'd0 : 32'(v.exp_resp - 1));
        check32({tag, "_rdata"}, lsu_rdata_op, v.exp_rdata);
    endtask

    // ---------------- main sequence ----------------
    int   resp_cnt;
    int   accepts;
    int   resp_c0;
    int   resp_c1;
    int   phase;
    logic err_any;
    logic we_second;
    logic gnt_prev;

    initial begin
        reset = 1'b1;
        lsu_req_ip = 1'b0; lsu_operator_ip = LSU_LW; lsu_addr_ip = 32'h0; lsu_wdata_ip = 32'h0;
        mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        check32("rst_ready", {31'b0, lsu_ready_op}, 32'd1);
        check32("rst_resp",  {31'b0, lsu_resp_op},  32'd0);
        check32("rst_err",   {31'b0, lsu_err_op},   32'd0);
        check32("rst_rdata", lsu_rdata_op, 32'h0);
        check32("rst_req",   {31'b0, mem_req_op},   32'd0);
        check32("rst_we",    {31'b0, mem_we_op},    32'd0);
        check32("rst_addr",  mem_addr_op,  32'h0);
        check32("rst_wdata", mem_wdata_op, 32'h0);
        check32("rst_state", {30'b0, dbg_state_op}, {30'b0, DMC_IDLE});

        //            op      addr          wdata         gw  rv  rdata         resp err req exp_addr      we   exp_rdata
        vecs[0]  = mk(LSU_LW, 32'h0000_0100, 32'h0,        0, 1, 32'hDEADBEEF, 3,  0,  1,  32'h0000_0100, 0, 32'hDEADBEEF);
        vecs[1]  = mk(LSU_SW, 32'h0000_0204, 32'h12345678, 3, 1, 32'hFFFF0000, 6,  0,  4,  32'h0000_0204, 1, 32'hDEADBEEF);
        vecs[2]  = mk(LSU_LW, 32'h0000_0102, 32'h0,        0, 1, 32'h0,        1,  1,  0,  32'h0,         0, 32'hDEADBEEF);
        vecs[3]  = mk(LSU_SW, 32'h0000_0301, 32'h1,        0, 1, 32'h0,        1,  1,  0,  32'h0,         1, 32'hDEADBEEF);
        vecs[4]  = mk(LSU_LB, 32'h0000_0400, 32'h0,        0, 1, 32'h0,        1,  1,  0,  32'h0,         0, 32'hDEADBEEF);
        vecs[5]  = mk(LSU_LW, 32'hFFFF_FFFC, 32'h0,        1, 1, 32'hA5A50F0F, 4,  0,  2,  32'hFFFF_FFFC, 0, 32'hA5A50F0F);
        vecs[6]  = mk(LSU_LW, 32'h0000_0008, 32'h0,        6, 1, 32'h0BADF00D, 9,  0,  7,  32'h0000_0008, 0, 32'h0BADF00D);
        vecs[7]  = mk(LSU_LW, 32'h0000_0020, 32'h0,        7, 1, 32'h13579BDF, 10, 0,  8,  32'h0000_0020, 0, 32'h13579BDF);
        vecs[8]  = mk(LSU_LW, 32'h0000_0040, 32'h0,       -1, 0, 32'h0,        9,  1,  8,  32'h0000_0040, 0, 32'h13579BDF);
        vecs[9]  = mk(LSU_LW, 32'h0000_0044, 32'h0,        0, 0, 32'h0,        9,  1,  1,  32'h0000_0044, 0, 32'h13579BDF);
        vecs[10] = mk(LSU_SW, 32'h0000_0010, 32'hCAFEF00D, 0, 1, 32'h55555555, 3,  0,  1,  32'h0000_0010, 1, 32'h13579BDF);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Timeout followed by a late response that must be ignored
        run_vec(mk(LSU_LW, 32'h0000_0048, 32'h0, -1, 0, 32'h0, 9, 1, 8, 32'h0000_0048, 0, 32'h13579BDF), 11);
        resp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (lsu_resp_op) resp_cnt++;
            mem_rvalid_ip = (c < 2);
            mem_rdata_ip  = 32'hBAD0BAD0;
        end
        mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'h0;
        @(negedge clock);
        if (lsu_resp_op) resp_cnt++;
        check32("late_rvalid_resp", 32'(resp_cnt), 32'd0);
        check32("late_rvalid_rdata", lsu_rdata_op, 32'h13579BDF);
        check32("late_rvalid_state", {30'b0, dbg_state_op}, {30'b0, DMC_IDLE});

        // Reset while waiting for the response phase
        @(negedge clock);
        lsu_req_ip = 1'b1; lsu_operator_ip = LSU_LW; lsu_addr_ip = 32'h0000_0500; lsu_wdata_ip = 32'h0;
        @(negedge clock);
        lsu_req_ip = 1'b0;
        check32("mid_rst_req", {31'b0, mem_req_op}, 32'd1);
        mem_gnt_ip = 1'b1;
        @(negedge clock);
        mem_gnt_ip = 1'b0;
        check32("mid_rst_in_wait", {30'b0, dbg_state_op}, {30'b0, DMC_WAIT_R});
        reset = 1'b1;
        mem_rvalid_ip = 1'b1; mem_rdata_ip = 32'h77777777;
        @(negedge clock);
        reset = 1'b0;
        mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'h0;
        check32("mid_rst_state", {30'b0, dbg_state_op}, {30'b0, DMC_IDLE});
        check32("mid_rst_ready", {31'b0, lsu_ready_op}, 32'd1);
        check32("mid_rst_resp",  {31'b0, lsu_resp_op},  32'd0);
        check32("mid_rst_err",   {31'b0, lsu_err_op},   32'd0);
        check32("mid_rst_rdata", lsu_rdata_op, 32'h0);
        check32("mid_rst_busreq", {31'b0, mem_req_op}, 32'd0);
        check32("mid_rst_addr",  mem_addr_op, 32'h0);
        resp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (lsu_resp_op) resp_cnt++;
        end
        check32("mid_rst_no_resp", 32'(resp_cnt), 32'd0);
        run_vec(mk(LSU_LW, 32'h0000_0504, 32'h0, 2, 1, 32'h600DCAFE, 5, 0, 3, 32'h0000_0504, 0, 32'h600DCAFE), 12);

        // Back-to-back LW then SW with the request held high throughout
        @(negedge clock);
        lsu_req_ip = 1'b1; lsu_operator_ip = LSU_LW; lsu_addr_ip = 32'h0000_0600; lsu_wdata_ip = 32'h0;
        accepts = (lsu_ready_op && lsu_req_ip) ? 1 : 0;
        resp_cnt = 0; resp_c0 = -1; resp_c1 = -1; phase = 0;
        err_any = 1'b0; we_second = 1'b0; gnt_prev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            mem_rvalid_ip = gnt_prev;
            mem_rdata_ip  = gnt_prev ? ((phase == 0) ? 32'h11112222 : 32'h99999999) : 32'h0;
            mem_gnt_ip    = mem_req_op;
            gnt_prev      = mem_gnt_ip;
            if (mem_req_op && phase == 1) we_second = mem_we_op;
            if (lsu_resp_op) begin
                resp_cnt++;
                err_any = err_any | lsu_err_op;
                if (phase == 0) begin
                    resp_c0 = c;
                    phase = 1;
                    lsu_operator_ip = LSU_SW; lsu_addr_ip = 32'h0000_0604; lsu_wdata_ip = 32'hABCDEF01;
                end else begin
                    if (resp_c1 < 0) resp_c1 = c;
                    lsu_req_ip = 1'b0;
                end
            end
            if (lsu_ready_op && lsu_req_ip) accepts++;
        end
        mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'h0;
        check32("b2b_accepts",  32'(accepts),  32'd2);
        check32("b2b_resp_cnt", 32'(resp_cnt), 32'd2);
        check32("b2b_resp0_cycle", 32'(resp_c0), 32'd3);
        check32("b2b_resp1_cycle", 32'(resp_c1), 32'd6);
        check32("b2b_err", {31'b0, err_any}, 32'd0);
        check32("b2b_second_we", {31'b0, we_second}, 32'd1);
        check32("b2b_rdata", lsu_rdata_op, 32'h11112222);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
